// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types: FSM states, queue entry, NOP and reset PC
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_2000;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: imem request/response, redirect, decode handshake
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous {pc, inst} FIFO with flush and simultaneous push/pop
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        // A full queue still accepts a push when the head leaves in the same cycle
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with redirect drain; FETCH_BYPASS_EN adds response-to-decode bypass
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [31:0]   hold_inst_q, hold_inst_d, hold_pc_q, hold_pc_d;
    logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, q_count;
    logic [31:0]   redirect_pc_aligned;
    logic          req_valid, accept, resp_tracked, resp_live, push, pop;
    logic          dec_valid, q_full, q_empty;
    logic [31:0]   dec_inst, dec_pc;
    fetch_entry_t  q_head, q_push_data;
`ifdef FETCH_BYPASS_EN
    logic          bypass;
`endif

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.redirect_valid),
        .push_i      (push),
        .push_data_i (q_push_data),
        .pop_i       (pop),
        .head_o      (q_head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    always_comb begin
        redirect_pc_aligned = bus.redirect_pc & ~32'd3;
        // Responses with nothing outstanding (e.g. left over from before reset) are ignored
        resp_tracked = bus.imem_resp_valid && (inflight_q != '0);
        resp_live    = resp_tracked && (drop_q == '0) && !bus.redirect_valid;
        pop          = bus.dec_ready && !q_empty;
        req_valid    = (state_q == ST_RUN) &&
                       ((32'(inflight_q) + 32'(q_count) - 32'(pop)) < 32'(QDEPTH));
        accept       = req_valid && bus.imem_req_ready;
        q_push_data  = '{pc: resp_pc_q, inst: bus.imem_resp_data};
`ifdef FETCH_BYPASS_EN
        bypass    = resp_live && q_empty;
        dec_valid = !q_empty || bypass;
        dec_inst  = !q_empty ? q_head.inst : (bypass ? bus.imem_resp_data : hold_inst_q);
        dec_pc    = !q_empty ? q_head.pc   : (bypass ? resp_pc_q : hold_pc_q);
        push      = resp_live && !(bypass && bus.dec_ready);
`else
        dec_valid = !q_empty;
        dec_inst  = q_empty ? hold_inst_q : q_head.inst;
        dec_pc    = q_empty ? hold_pc_q   : q_head.pc;
        push      = resp_live;
`endif
        hold_inst_d = dec_valid ? dec_inst : hold_inst_q;
        hold_pc_d   = dec_valid ? dec_pc   : hold_pc_q;

        // Live responses are always contiguous, so the PC side-queue collapses to a counter
        fetch_pc_d = bus.redirect_valid ? redirect_pc_aligned :
                     (accept ? fetch_pc_q + 32'd4 : fetch_pc_q);
        resp_pc_d  = bus.redirect_valid ? redirect_pc_aligned :
                     (resp_live ? resp_pc_q + 32'd4 : resp_pc_q);
        inflight_d = inflight_q + CW'(accept) - CW'(resp_tracked);

        drop_d = drop_q;
        if (bus.redirect_valid)                  drop_d = inflight_d;
        else if (resp_tracked && drop_q != '0)   drop_d = drop_q - CW'(1);

        state_d = state_q;
        case (state_q)
            ST_IDLE:         state_d = ST_RUN;
            ST_RUN, ST_DRAIN: state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
            default:         state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            inflight_q  <= '0;
            drop_q      <= '0;
            hold_inst_q <= NOP_INST;
            hold_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    always @(posedge clk) begin
        if (!rst) assert (!(push && q_full && !pop));
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.dec_valid      = dec_valid;
    assign bus.dec_inst       = dec_inst;
    assign bus.dec_pc         = dec_pc;
endmodule
